// File: rtl/int_reg_file.sv
// Integer register file with a post-reset clear sequence and optional write-to-read forwarding.
// Latency: reads are registered, so rs_rdata reflects rs_addr one clk edge later; writes land on the edge.
// Backpressure: none; ready only reports that the post-reset clear has finished, and nothing stalls.
module int_reg_file #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_wen,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_wdata,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_rdata,
  output logic                ready
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam bit             ZR   = (ZERO_REG != 0);
  localparam bit             BP   = (BYPASS != 0);
  localparam bit             POW2 = (NREG == (1 << AW));
  localparam logic [AW-1:0]  LAST = AW'(NREG - 1);

  state_t                state;
  logic [AW-1:0]         clr_cnt;
  logic [XLEN-1:0]       mem [NREG];
  logic                  wr_in_rng;
  logic                  wr_ok;
  logic [NRD*XLEN-1:0]   rd_nxt;

  // Only non-power-of-two register counts can see out-of-range addresses.
  if (POW2) begin : g_wr_full
    assign wr_in_rng = 1'b1;
  end else begin : g_wr_part
    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);
    assign wr_in_rng = ({1'b0, rd_addr} < NREG_L);
  end

  // A write takes effect only in RUN, in range, and not aimed at a hardwired zero register.
  assign wr_ok = (state == RUN) && rd_wen && wr_in_rng && !(ZR && (rd_addr == '0));

  // Clear sequencer: walk every register once after reset, then run; ready trails RUN by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= (state == RUN);
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state   <= RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Storage has no reset; the clear sequence is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[rd_addr] <= rd_wdata;
    end
  end

  // Each read port decides independently from its own address.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          a_in_rng;
    assign a = rs_addr[g*AW +: AW];
    if (POW2) begin : g_full
      assign a_in_rng = 1'b1;
    end else begin : g_part
      localparam logic [AW:0] NREG_L = (AW+1)'(NREG);
      assign a_in_rng = ({1'b0, a} < NREG_L);
    end
    assign rd_nxt[g*XLEN +: XLEN] =
      ((state != RUN) || !a_in_rng || (ZR && (a == '0))) ? '0 :
      (BP && wr_ok && (a == rd_addr))                     ? rd_wdata :
                                                            mem[a];
  end

  // Registered read data keeps every output off any combinational input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_rdata <= '0;
    end else begin
      rs_rdata <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_int_reg_file.sv
// Directed bench for int_reg_file across four parameter builds sharing one clock and reset.
// Expected read data and ready levels are queued before each edge and checked just after it.
// Builds: defaults, no-bypass, 64-bit/16-reg/3-port, and 8-bit/6-reg/1-port without a zero register.
module tb_int_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default build and no-bypass build share their inputs.
  logic        a_wen;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [9:0]  a_rs;
  logic [63:0] a_rd, b_rd;
  logic        a_rdy, b_rdy;

  logic         w_wen;
  logic [3:0]   w_waddr;
  logic [63:0]  w_wdata;
  logic [11:0]  w_rs;
  logic [191:0] w_rd;
  logic         w_rdy;

  logic       s_wen;
  logic [2:0] s_waddr;
  logic [7:0] s_wdata;
  logic [2:0] s_rs;
  logic [7:0] s_rd;
  logic       s_rdy;

  int_reg_file dut_a (
    .clk(clk), .rst_n(rst_n), .rd_wen(a_wen), .rd_addr(a_waddr), .rd_wdata(a_wdata),
    .rs_addr(a_rs), .rs_rdata(a_rd), .ready(a_rdy));

  int_reg_file #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_wen(a_wen), .rd_addr(a_waddr), .rd_wdata(a_wdata),
    .rs_addr(a_rs), .rs_rdata(b_rd), .ready(b_rdy));

  int_reg_file #(.XLEN(64), .NREG(16), .NRD(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .rd_wen(w_wen), .rd_addr(w_waddr), .rd_wdata(w_wdata),
    .rs_addr(w_rs), .rs_rdata(w_rd), .ready(w_rdy));

  int_reg_file #(.XLEN(8), .NREG(6), .NRD(1), .ZERO_REG(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .rd_wen(s_wen), .rd_addr(s_waddr), .rd_wdata(s_wdata),
    .rs_addr(s_rs), .rs_rdata(s_rd), .ready(s_rdy));

  // sel: 0 a data, 1 b data, 2 w data, 3 a ready, 4 b ready, 5 w ready, 6 s data, 7 s ready
  typedef struct {
    string       tag;
    int          sel;
    int          port;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [63:0] obs(input int sel, input int port);
    case (sel)
      0:       return {32'b0, a_rd[port*32 +: 32]};
      1:       return {32'b0, b_rd[port*32 +: 32]};
      2:       return w_rd[port*64 +: 64];
      3:       return {63'b0, a_rdy};
      4:       return {63'b0, b_rdy};
      5:       return {63'b0, w_rdy};
      6:       return {56'b0, s_rd};
      7:       return {63'b0, s_rdy};
      default: return '1;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int port, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.port = port; e.val = val;
    sb.push_back(e);
  endtask

  // Advance one edge, then drain the scoreboard against what the DUTs now show.
  task automatic cyc();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] o;
      e = sb.pop_front();
      o = obs(e.sel, e.port);
      n_chk++;
      assert (o === e.val)
        else begin
          n_fail++;
          $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
        end
    end
  endtask

  task automatic a_in(input logic wen, input logic [4:0] ad, input logic [31:0] d,
                      input logic [4:0] r0, input logic [4:0] r1);
    a_wen = wen; a_waddr = ad; a_wdata = d; a_rs = {r1, r0};
  endtask

  task automatic w_in(input logic wen, input logic [3:0] ad, input logic [63:0] d,
                      input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    w_wen = wen; w_waddr = ad; w_wdata = d; w_rs = {r2, r1, r0};
  endtask

  task automatic s_in(input logic wen, input logic [2:0] ad, input logic [7:0] d,
                      input logic [2:0] r0);
    s_wen = wen; s_waddr = ad; s_wdata = d; s_rs = r0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    a_in(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    w_in(1'b1, 4'd4, 64'hCAFE, 4'd4, 4'd4, 4'd4);
    s_in(1'b1, 3'd3, 8'h5A, 3'd3);
    #1 rst_n = 1'b0;

    // Reset state
    push("rst_a_rd0", 0, 0, 64'd0);
    push("rst_a_rd1", 0, 1, 64'd0);
    push("rst_a_rdy", 3, 0, 64'd0);
    push("rst_w_rd2", 2, 2, 64'd0);
    push("rst_w_rdy", 5, 0, 64'd0);
    push("rst_s_rdy", 7, 0, 64'd0);
    cyc();
    cyc();

    // Clear timing with writes held during CLEAR
    rst_n = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      if (n == 33) a_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
      if (n == 17) w_in(1'b0, 4'd0, 64'd0, 4'd4, 4'd4, 4'd4);
      if (n == 7)  s_in(1'b0, 3'd0, 8'd0, 3'd3);
      push("clr_a_rdy", 3, 0, (n >= 33) ? 64'd1 : 64'd0);
      push("clr_b_rdy", 4, 0, (n >= 33) ? 64'd1 : 64'd0);
      push("clr_w_rdy", 5, 0, (n >= 17) ? 64'd1 : 64'd0);
      push("clr_s_rdy", 7, 0, (n >= 7)  ? 64'd1 : 64'd0);
      push("clr_a_rd0", 0, 0, 64'd0);
      cyc();
    end

    // Write r7, read it on both ports next cycle
    a_in(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
    cyc();
    a_in(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    push("rw_a_p0", 0, 0, 64'h12345678);
    push("rw_a_p1", 0, 1, 64'h12345678);
    push("rw_b_p0", 1, 0, 64'h12345678);
    push("rw_b_p1", 1, 1, 64'h12345678);
    cyc();

    // Zero register ignores writes; other port unaffected
    a_in(1'b1, 5'd3, 32'hA5, 5'd0, 5'd0);
    cyc();
    a_in(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3);
    push("z_a_p0", 0, 0, 64'd0);
    push("z_a_p1", 0, 1, 64'hA5);
    push("z_b_p0", 1, 0, 64'd0);
    push("z_b_p1", 1, 1, 64'hA5);
    cyc();
    a_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd7);
    push("z_after_p0", 0, 0, 64'd0);
    push("z_after_p1", 0, 1, 64'h12345678);
    cyc();

    // Bypass on / off
    a_in(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
    cyc();
    a_in(1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
    push("byp_a_p0", 0, 0, 64'h2);
    push("byp_a_p1", 0, 1, 64'h2);
    push("nobyp_b_p0", 1, 0, 64'h1);
    push("nobyp_b_p1", 1, 1, 64'h1);
    cyc();
    a_in(1'b1, 5'd10, 32'h77, 5'd10, 5'd9);
    push("byp1_a_p0", 0, 0, 64'h77);
    push("byp1_a_p1", 0, 1, 64'h2);
    push("byp1_b_p0", 1, 0, 64'h0);
    push("byp1_b_p1", 1, 1, 64'h2);
    cyc();
    a_in(1'b0, 5'd0, 32'd0, 5'd9, 5'd10);
    push("vis_a_p0", 0, 0, 64'h2);
    push("vis_b_p0", 1, 0, 64'h2);
    push("vis_b_p1", 1, 1, 64'h77);
    cyc();

    // Wide build: distinct registers on three ports
    w_in(1'b1, 4'd2, 64'h0123456789ABCDEF, 4'd4, 4'd0, 4'd0);
    push("w_r4_clr", 2, 0, 64'd0);
    cyc();
    w_in(1'b1, 4'd5, 64'hFEDCBA9876543210, 4'd0, 4'd0, 4'd0);
    cyc();
    w_in(1'b1, 4'd15, 64'h8000000000000001, 4'd0, 4'd0, 4'd0);
    cyc();
    w_in(1'b0, 4'd0, 64'd0, 4'd2, 4'd5, 4'd15);
    push("w_p0", 2, 0, 64'h0123456789ABCDEF);
    push("w_p1", 2, 1, 64'hFEDCBA9876543210);
    push("w_p2", 2, 2, 64'h8000000000000001);
    cyc();
    w_in(1'b1, 4'd15, 64'hAAAA5555AAAA5555, 4'd15, 4'd0, 4'd2);
    push("w_byp_p0", 2, 0, 64'hAAAA5555AAAA5555);
    push("w_byp_p1", 2, 1, 64'd0);
    push("w_byp_p2", 2, 2, 64'h0123456789ABCDEF);
    cyc();

    // Small build: writable r0, out-of-range addresses
    s_in(1'b1, 3'd0, 8'h11, 3'd3);
    push("s_r3_clr", 6, 0, 64'd0);
    cyc();
    s_in(1'b1, 3'd5, 8'h22, 3'd0);
    push("s_r0", 6, 0, 64'h11);
    cyc();
    s_in(1'b1, 3'd6, 8'h33, 3'd6);
    push("s_oor_rd", 6, 0, 64'd0);
    cyc();
    s_in(1'b1, 3'd7, 8'h44, 3'd5);
    push("s_r5", 6, 0, 64'h22);
    cyc();
    s_in(1'b1, 3'd0, 8'h55, 3'd0);
    push("s_r0_byp", 6, 0, 64'h55);
    cyc();

    // Reset during RUN, then again mid-CLEAR
    a_in(1'b0, 5'd0, 32'd0, 5'd7, 5'd9);
    w_in(1'b0, 4'd0, 64'd0, 4'd2, 4'd5, 4'd15);
    s_in(1'b0, 3'd0, 8'd0, 3'd5);
    rst_n = 1'b0;
    push("rr_a_rdy", 3, 0, 64'd0);
    push("rr_a_p0", 0, 0, 64'd0);
    push("rr_w_rdy", 5, 0, 64'd0);
    cyc();
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      push("rr_clr_rdy", 3, 0, 64'd0);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      push("rr2_a_rdy", 3, 0, (n >= 33) ? 64'd1 : 64'd0);
      cyc();
    end
    a_in(1'b0, 5'd0, 32'd0, 5'd3, 5'd10);
    push("rr_r3", 0, 0, 64'd0);
    push("rr_r10", 0, 1, 64'd0);
    cyc();
    a_in(1'b0, 5'd0, 32'd0, 5'd9, 5'd7);
    push("rr_r9", 0, 0, 64'd0);
    push("rr_r7", 0, 1, 64'd0);
    push("rr_b_r9", 1, 0, 64'd0);
    push("rr_w_r2", 2, 0, 64'd0);
    push("rr_w_r15", 2, 2, 64'd0);
    push("rr_s_r5", 6, 0, 64'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
